// File: rtl/bus_cycle_controller_if.sv
// bus_cycle_controller_if: bus strobes, decode inputs and DSACK/BERR responses of one bus cycle controller.
interface bus_cycle_controller_if #(
  parameter int CHANNELS = 8,
  parameter int WS_WIDTH = 4
);
  logic                         as;
  logic [CHANNELS-1:0]          cs;
  logic [1:0]                   port_width;
  logic [CHANNELS*WS_WIDTH-1:0] ws_config;
  logic                         ext_wait;
  logic                         fpu_selected;
  logic [1:0]                   n_dsack;
  logic                         dsack_oe;
  logic                         n_berr;
  logic                         busy;
  modport master (
    output as, cs, port_width, ws_config, ext_wait, fpu_selected,
    input  n_dsack, dsack_oe, n_berr, busy
  );
  modport slave (
    input  as, cs, port_width, ws_config, ext_wait, fpu_selected,
    output n_dsack, dsack_oe, n_berr, busy
  );
endinterface

// File: rtl/bus_cycle_controller.sv
// bus_cycle_controller: wait-state insertion, DSACK sizing, bus-error timeout and coprocessor pass-through.
module bus_cycle_controller #(
  parameter int CHANNELS = 8,
  parameter int WS_WIDTH = 4,
  parameter int TIMEOUT  = 255
) (
  input logic                   clock,
  input logic                   n_reset,
  bus_cycle_controller_if.slave bus
);
  localparam int TO_WIDTH = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT, ACK, BERR, PASS} state_t;
  state_t              state_q, state_d;
  logic [WS_WIDTH-1:0] cnt_q, cnt_d, ws_sel;
  logic [TO_WIDTH-1:0] to_q, to_d, to_inc;
  logic [1:0]          width_q, width_d;
  logic                armed_q, armed_d;
  logic                to_hit, start;
  always_comb begin
    ws_sel = '0;
    for (int i = 0; i < CHANNELS; i++)
      ws_sel = ws_sel | (bus.cs[i] ? bus.ws_config[i*WS_WIDTH +: WS_WIDTH] : '0);
  end
  // armed_q: an IDLE edge has seen as low since the last cycle (or reset)
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    armed_d = armed_q;
    to_inc  = to_q + TO_WIDTH'(1);
    to_hit  = bus.as && to_inc == TO_WIDTH'(TIMEOUT);
    start   = bus.as && armed_q;
    to_d    = (state_q == IDLE && !bus.as) ? '0 :
              (bus.as && (state_q == IDLE || state_q == WAIT)) ? to_inc : to_q;
    case (state_q)
      IDLE: begin
        if (start && bus.fpu_selected) state_d = PASS;
        else if (to_hit) state_d = BERR;
        else if (start && |bus.cs) begin
          if (!$onehot(bus.cs) || bus.port_width == 2'b00) state_d = BERR;
          else begin
            width_d = bus.port_width;
            cnt_d   = ws_sel;
            state_d = (ws_sel == '0 && !bus.ext_wait) ? ACK : WAIT;
          end
        end
        armed_d = !bus.as || (armed_q && state_d == IDLE);
      end
      WAIT: begin
        if (!bus.as) state_d = IDLE;
        else if (to_hit) state_d = BERR;
        else if (!bus.ext_wait) begin
          cnt_d   = cnt_q - WS_WIDTH'(1);
          state_d = cnt_q <= WS_WIDTH'(1) ? ACK : WAIT;
        end
      end
      ACK, BERR, PASS: state_d = bus.as ? state_q : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      to_q    <= '0;
      width_q <= '0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
      width_q <= width_d;
      armed_q <= armed_d;
    end
  end
  // width 11/10/01 maps to DSACK 00/01/10
  assign bus.n_dsack  = state_q == ACK ? ~width_q : 2'b11;
  assign bus.dsack_oe = state_q != PASS;
  assign bus.n_berr   = state_q != BERR;
  assign bus.busy     = state_q != IDLE;
endmodule
